// File: rtl/game_pkg.sv
// Shared definitions for the memory-game scoring/display path: result codes,
// FSM encoding, seven-segment glyphs and BCD helpers.
package game_pkg;

    localparam int unsigned RES_W   = 2;
    localparam int unsigned BCD2_W  = 8;
    localparam int unsigned SEG_W   = 7;

    localparam logic [RES_W-1:0] RES_MISS  = 2'd0;
    localparam logic [RES_W-1:0] RES_PERM  = 2'd1;
    localparam logic [RES_W-1:0] RES_EXACT = 2'd2;

    typedef enum logic {
        IDLE = 1'b0,
        ADD  = 1'b1
    } state_e;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [SEG_W-1:0] GLYPH_0     = 7'b1000000;
    localparam logic [SEG_W-1:0] GLYPH_1     = 7'b1111001;
    localparam logic [SEG_W-1:0] GLYPH_2     = 7'b0100100;
    localparam logic [SEG_W-1:0] GLYPH_3     = 7'b0110000;
    localparam logic [SEG_W-1:0] GLYPH_4     = 7'b0011001;
    localparam logic [SEG_W-1:0] GLYPH_5     = 7'b0010010;
    localparam logic [SEG_W-1:0] GLYPH_6     = 7'b0000010;
    localparam logic [SEG_W-1:0] GLYPH_7     = 7'b1111000;
    localparam logic [SEG_W-1:0] GLYPH_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] GLYPH_9     = 7'b0010000;
    localparam logic [SEG_W-1:0] GLYPH_BLANK = 7'b1111111;

    // Two-digit BCD increment that holds once the value reaches limit.
    // Plain magnitude compare is valid because BCD preserves ordering.
    function automatic logic [BCD2_W-1:0] bcd_inc_sat(input logic [BCD2_W-1:0] v,
                                                      input logic [BCD2_W-1:0] limit);
        logic [BCD2_W-1:0] r;
        if (v >= limit) begin
            r = v;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    function automatic logic [BCD2_W-1:0] to_bcd(input int unsigned n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-low seven-segment pattern; out-of-range digits blank.
module seg7_decode
    import game_pkg::*;
(
    input  logic [3:0]       digit,
    output logic [SEG_W-1:0] seg_c
);

    always_comb begin
        seg_c = GLYPH_BLANK;
        case (digit)
            4'd0:    seg_c = GLYPH_0;
            4'd1:    seg_c = GLYPH_1;
            4'd2:    seg_c = GLYPH_2;
            4'd3:    seg_c = GLYPH_3;
            4'd4:    seg_c = GLYPH_4;
            4'd5:    seg_c = GLYPH_5;
            4'd6:    seg_c = GLYPH_6;
            4'd7:    seg_c = GLYPH_7;
            4'd8:    seg_c = GLYPH_8;
            4'd9:    seg_c = GLYPH_9;
            default: seg_c = GLYPH_BLANK;
        endcase
    end

endmodule

// File: rtl/score_display.sv
// Accumulates BCD score and round count from game-core verdicts and scans
// them onto a 4-digit multiplexed seven-segment display (rounds | score).
module score_display
    import game_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned PTS_EXACT   = 3,
    parameter int unsigned PTS_PERM    = 1,
    parameter int unsigned MAX_ROUNDS  = 99
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             res_valid,
    input  logic [RES_W-1:0] res_code,
    input  logic             clear,
    output logic             res_ready,
    output logic             game_over,
    output logic             overrun,
    output logic [SEG_W-1:0] seg,
    output logic             dp,
    output logic [3:0]       an
);

    localparam int unsigned      CNT_W      = $clog2(REFRESH_DIV);
    localparam int unsigned      PEND_W     = 3;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [BCD2_W-1:0] SCORE_MAX  = 8'h99;
    localparam logic [BCD2_W-1:0] ROUNDS_MAX = to_bcd(MAX_ROUNDS);
    localparam logic [PEND_W-1:0] PTS_E      = PEND_W'(PTS_EXACT);
    localparam logic [PEND_W-1:0] PTS_P      = PEND_W'(PTS_PERM);

    state_e              state_q, state_d;
    logic [BCD2_W-1:0]   score_q, score_d;
    logic [BCD2_W-1:0]   rounds_q, rounds_d;
    logic [PEND_W-1:0]   pending_q, pending_d;
    logic                game_over_q, game_over_d;
    logic                overrun_q, overrun_d;
    logic [CNT_W-1:0]    refresh_q, refresh_d;
    logic [1:0]          idx_q, idx_d;
    logic [3:0]          an_q, an_d;
    logic [SEG_W-1:0]    seg_q, seg_d;
    logic                dp_q, dp_d;
    logic [PEND_W-1:0]   pts_c;
    logic [3:0]          digit_c;
    logic [SEG_W-1:0]    glyph_c;

    assign res_ready = (state_q == IDLE) && !game_over_q;
    assign game_over = game_over_q;
    assign overrun   = overrun_q;
    assign seg       = seg_q;
    assign dp        = dp_q;
    assign an        = an_q;

    // Reserved code scores like a miss.
    always_comb begin
        pts_c = '0;
        if (res_code == RES_EXACT) begin
            pts_c = PTS_E;
        end else if (res_code == RES_PERM) begin
            pts_c = PTS_P;
        end
    end

    // Scoring FSM; clear overrides everything, including a pending result.
    always_comb begin
        state_d     = state_q;
        score_d     = score_q;
        rounds_d    = rounds_q;
        pending_d   = pending_q;
        game_over_d = (rounds_q == ROUNDS_MAX);
        overrun_d   = overrun_q;
        if (clear) begin
            state_d     = IDLE;
            score_d     = '0;
            rounds_d    = '0;
            pending_d   = '0;
            game_over_d = 1'b0;
            overrun_d   = 1'b0;
        end else begin
            if (res_valid && !res_ready) begin
                overrun_d = 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (res_valid && res_ready) begin
                        rounds_d  = bcd_inc_sat(rounds_q, ROUNDS_MAX);
                        pending_d = pts_c;
                        if (pts_c != '0) begin
                            state_d = ADD;
                        end
                    end
                end
                ADD: begin
                    score_d   = bcd_inc_sat(score_q, SCORE_MAX);
                    pending_d = pending_q - PEND_W'(1);
                    if (pending_q == PEND_W'(1)) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        case (idx_q)
            2'd0:    digit_c = score_q[3:0];
            2'd1:    digit_c = score_q[7:4];
            2'd2:    digit_c = rounds_q[3:0];
            default: digit_c = rounds_q[7:4];
        endcase
    end

    seg7_decode u_seg7_decode (
        .digit (digit_c),
        .seg_c (glyph_c)
    );

    // Display scan; independent of clear.
    always_comb begin
        refresh_d = refresh_q + CNT_W'(1);
        idx_d     = idx_q;
        if (refresh_q == CNT_LAST) begin
            refresh_d = '0;
            idx_d     = idx_q + 2'd1;
        end
        an_d  = ~(4'b0001 << idx_q);
        seg_d = glyph_c;
        dp_d  = (idx_q != 2'd2);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            score_q     <= '0;
            rounds_q    <= '0;
            pending_q   <= '0;
            game_over_q <= 1'b0;
            overrun_q   <= 1'b0;
            refresh_q   <= '0;
            idx_q       <= '0;
            an_q        <= 4'b1110;
            seg_q       <= GLYPH_0;
            dp_q        <= 1'b1;
        end else begin
            state_q     <= state_d;
            score_q     <= score_d;
            rounds_q    <= rounds_d;
            pending_q   <= pending_d;
            game_over_q <= game_over_d;
            overrun_q   <= overrun_d;
            refresh_q   <= refresh_d;
            idx_q       <= idx_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
        end
    end

endmodule

// File: tb/tb_score_display.sv
// Scoreboard bench for score_display: two instances (MAX_ROUNDS 99 and 3),
// expected score/rounds queued per transaction and compared via the display scan.
module tb_score_display;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       res_valid, clear, res_ready, game_over, overrun, dp;
    logic [1:0] res_code;
    logic [6:0] seg;
    logic [3:0] an;

    logic       g_valid, g_clear, g_ready, g_game_over, g_overrun, g_dp;
    logic [1:0] g_code;
    logic [6:0] g_seg;
    logic [3:0] g_an;

    score_display #(.REFRESH_DIV(4), .PTS_EXACT(3), .PTS_PERM(1), .MAX_ROUNDS(99)) u_dut (
        .clk(clk), .reset_n(reset_n), .res_valid(res_valid), .res_code(res_code),
        .clear(clear), .res_ready(res_ready), .game_over(game_over), .overrun(overrun),
        .seg(seg), .dp(dp), .an(an)
    );

    score_display #(.REFRESH_DIV(4), .PTS_EXACT(3), .PTS_PERM(1), .MAX_ROUNDS(3)) u_go (
        .clk(clk), .reset_n(reset_n), .res_valid(g_valid), .res_code(g_code),
        .clear(g_clear), .res_ready(g_ready), .game_over(g_game_over), .overrun(g_overrun),
        .seg(g_seg), .dp(g_dp), .an(g_an)
    );

    typedef struct {
        int score;
        int rounds;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   m_score  = 0;
    int   m_rounds = 0;

    task automatic check_val(input string tag, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic int glyph2dig(input logic [6:0] g);
        case (g)
            7'b1000000: return 0;
            7'b1111001: return 1;
            7'b0100100: return 2;
            7'b0110000: return 3;
            7'b0011001: return 4;
            7'b0010010: return 5;
            7'b0000010: return 6;
            7'b1111000: return 7;
            7'b0000000: return 8;
            7'b0010000: return 9;
            default:    return -1;
        endcase
    endfunction

    function automatic logic [3:0] cur_an(input int sel);
        return (sel != 0) ? g_an : an;
    endfunction

    function automatic logic [6:0] cur_seg(input int sel);
        return (sel != 0) ? g_seg : seg;
    endfunction

    function automatic logic cur_dp(input int sel);
        return (sel != 0) ? g_dp : dp;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int t = 0;
        while (res_ready !== 1'b1 && t < 50) begin
            step();
            t++;
        end
        if (t >= 50) check_val("ready_timeout", 0, 1);
    endtask

    // Walk one full scan and rebuild the two counters from the glyphs shown.
    task automatic read_display(input int sel, output int sc, output int rd);
        int d[4];
        bit bad = 1'b0;
        step();
        for (int k = 0; k < 4; k++) begin
            int t = 0;
            logic [3:0] want;
            want = ~(4'b0001 << k);
            while (cur_an(sel) !== want && t < 40) begin
                step();
                t++;
            end
            if (t >= 40) check_val("an_timeout", int'(cur_an(sel)), int'(want));
            d[k] = glyph2dig(cur_seg(sel));
            if (d[k] < 0) bad = 1'b1;
            check_val("dp_digit", int'(cur_dp(sel)), (k == 2) ? 0 : 1);
        end
        sc = bad ? -1 : d[1] * 10 + d[0];
        rd = bad ? -1 : d[3] * 10 + d[2];
    endtask

    task automatic push_model();
        exp_t e;
        e.score  = m_score;
        e.rounds = m_rounds;
        exp_q.push_back(e);
    endtask

    task automatic compare_display(input int sel, input string tag);
        int sc, rd;
        exp_t e;
        read_display(sel, sc, rd);
        if (exp_q.size() == 0) begin
            check_val({tag, "_queue_empty"}, 0, 1);
        end else begin
            e = exp_q.pop_front();
            check_val({tag, "_score"}, sc, e.score);
            check_val({tag, "_rounds"}, rd, e.rounds);
        end
    endtask

    task automatic model_accept(input logic [1:0] code);
        int pts;
        pts = (code == 2'd2) ? 3 : (code == 2'd1) ? 1 : 0;
        m_rounds = (m_rounds < 99) ? m_rounds + 1 : 99;
        m_score  = (m_score + pts > 99) ? 99 : m_score + pts;
    endtask

    task automatic send(input logic [1:0] code, input bit chk, input string tag);
        wait_ready();
        res_valid = 1'b1;
        res_code  = code;
        step();
        res_valid = 1'b0;
        model_accept(code);
        wait_ready();
        if (chk) begin
            push_model();
            compare_display(0, tag);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        res_valid = 1'b0; res_code = 2'd0; clear = 1'b0;
        g_valid   = 1'b0; g_code   = 2'd0; g_clear = 1'b0;
        step(); step();

        check_val("rst_an", int'(an), 4'b1110);
        check_val("rst_seg", int'(seg), 7'b1000000);
        check_val("rst_dp", int'(dp), 1);
        check_val("rst_ready", int'(res_ready), 1);
        check_val("rst_game_over", int'(game_over), 0);
        check_val("rst_overrun", int'(overrun), 0);
        reset_n = 1'b1;

        // Idle scan: anodes rotate every 4 clocks, all digits show 0.
        begin
            int t = 0;
            while (an !== 4'b1101 && t < 20) begin
                step();
                t++;
            end
            if (t >= 20) check_val("scan_start_timeout", int'(an), 4'b1101);
            for (int i = 0; i < 16; i++) begin
                logic [3:0] want_an;
                want_an = ~(4'b0001 << ((1 + i / 4) % 4));
                check_val("scan_an", int'(an), int'(want_an));
                check_val("scan_seg", int'(seg), 7'b1000000);
                check_val("scan_dp", int'(dp), (want_an == 4'b1011) ? 0 : 1);
                step();
            end
        end

        // Single exact: ready low for three cycles, back on the fourth.
        wait_ready();
        res_valid = 1'b1; res_code = 2'd2;
        step();
        res_valid = 1'b0;
        model_accept(2'd2);
        check_val("exact_ready_t1", int'(res_ready), 0);
        step();
        check_val("exact_ready_t2", int'(res_ready), 0);
        step();
        check_val("exact_ready_t3", int'(res_ready), 0);
        step();
        check_val("exact_ready_t4", int'(res_ready), 1);
        push_model();
        compare_display(0, "exact1");

        // Result arriving mid-ADD is dropped and flagged.
        wait_ready();
        res_valid = 1'b1; res_code = 2'd2;
        step();
        res_valid = 1'b0;
        model_accept(2'd2);
        step();
        res_valid = 1'b1; res_code = 2'd1;
        step();
        res_valid = 1'b0;
        check_val("overrun_set", int'(overrun), 1);
        wait_ready();
        push_model();
        compare_display(0, "overrun");
        check_val("overrun_sticky", int'(overrun), 1);

        clear = 1'b1;
        step();
        clear = 1'b0;
        m_score = 0; m_rounds = 0;
        check_val("clear_overrun", int'(overrun), 0);
        push_model();
        compare_display(0, "clear");

        // clear with a concurrent result while an ADD is in flight.
        wait_ready();
        res_valid = 1'b1; res_code = 2'd2;
        step();
        clear = 1'b1; res_valid = 1'b1; res_code = 2'd2;
        step();
        clear = 1'b0; res_valid = 1'b0;
        m_score = 0; m_rounds = 0;
        check_val("clr_valid_ready", int'(res_ready), 1);
        check_val("clr_valid_overrun", int'(overrun), 0);
        push_model();
        compare_display(0, "clr_valid");

        // BCD carry, then preload to 98 and saturate.
        send(2'd2, 1'b0, "pre");
        send(2'd2, 1'b0, "pre");
        send(2'd1, 1'b0, "pre");
        send(2'd1, 1'b1, "score08");
        send(2'd1, 1'b1, "score09");
        send(2'd1, 1'b1, "score10");
        for (int i = 0; i < 29; i++) send(2'd2, 1'b0, "fill");
        send(2'd3, 1'b1, "reserved_miss");
        send(2'd1, 1'b1, "score98");
        send(2'd2, 1'b1, "score99");
        send(2'd2, 1'b1, "score99_hold");
        check_val("no_overrun_bulk", int'(overrun), 0);

        // Game over on the MAX_ROUNDS=3 instance: three back-to-back misses.
        g_code = 2'd0;
        for (int i = 0; i < 3; i++) begin
            check_val("go_ready_miss", int'(g_ready), 1);
            g_valid = 1'b1;
            step();
        end
        g_valid = 1'b0;
        begin
            int t = 0;
            while (g_game_over !== 1'b1 && t < 10) begin
                step();
                t++;
            end
            if (t >= 10) check_val("game_over_timeout", int'(g_game_over), 1);
        end
        check_val("go_game_over", int'(g_game_over), 1);
        check_val("go_ready_low", int'(g_ready), 0);
        check_val("go_no_overrun", int'(g_overrun), 0);
        g_valid = 1'b1; g_code = 2'd2;
        step();
        g_valid = 1'b0;
        check_val("go_overrun", int'(g_overrun), 1);
        begin
            exp_t e;
            e.score = 0;
            e.rounds = 3;
            exp_q.push_back(e);
        end
        compare_display(1, "go");

        // Async reset in the middle of an ADD.
        wait_ready();
        res_valid = 1'b1; res_code = 2'd2;
        step();
        res_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check_val("arst_an", int'(an), 4'b1110);
        check_val("arst_seg", int'(seg), 7'b1000000);
        check_val("arst_dp", int'(dp), 1);
        check_val("arst_ready", int'(res_ready), 1);
        check_val("arst_overrun", int'(overrun), 0);
        check_val("arst_game_over", int'(game_over), 0);
        check_val("arst_go_game_over", int'(g_game_over), 0);
        check_val("arst_go_overrun", int'(g_overrun), 0);
        step();
        reset_n = 1'b1;
        m_score = 0; m_rounds = 0;
        push_model();
        compare_display(0, "after_arst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
